// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per accepted start, MSB first, with optional
// slave-select hold so consecutive bytes can share one SSEL-low frame.
module spi_master #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       keep_ssel,
    output logic       ready,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SSEL
);

    localparam logic [7:0] RELOAD = 8'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GUARD
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  tx_sr, tx_sr_n;
    logic [7:0]  rx_sr, rx_sr_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic        keep, keep_n;
    logic        sck_n, mosi_n, ssel_n, done_n, ready_n;
    logic [7:0]  rx_data_n;
    logic        tick;

    // tick marks the last cycle of the current half-period
    assign tick = (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            keep    <= 1'b0;
            SCK     <= 1'b0;
            MOSI    <= 1'b0;
            SSEL    <= 1'b1;
            done    <= 1'b0;
            ready   <= 1'b1;
            rx_data <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tx_sr   <= tx_sr_n;
            rx_sr   <= rx_sr_n;
            bit_cnt <= bit_cnt_n;
            keep    <= keep_n;
            SCK     <= sck_n;
            MOSI    <= mosi_n;
            SSEL    <= ssel_n;
            done    <= done_n;
            ready   <= ready_n;
            rx_data <= rx_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = tick ? cnt : cnt - 8'd1;
        tx_sr_n   = tx_sr;
        rx_sr_n   = rx_sr;
        bit_cnt_n = bit_cnt;
        keep_n    = keep;
        sck_n     = SCK;
        mosi_n    = MOSI;
        ssel_n    = SSEL;
        done_n    = 1'b0;
        ready_n   = ready;
        rx_data_n = rx_data;

        unique case (state)
            IDLE: begin
                if (start) begin
                    tx_sr_n   = tx_data;
                    keep_n    = keep_ssel;
                    bit_cnt_n = '0;
                    ready_n   = 1'b0;
                    ssel_n    = 1'b0;
                    mosi_n    = tx_data[7];
                    cnt_n     = RELOAD;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sck_n   = 1'b1;
                    rx_sr_n = {rx_sr[6:0], MISO};
                    cnt_n   = RELOAD;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    cnt_n = RELOAD;
                    if (SCK) begin
                        // falling edge: present the next bit, or finish after the 8th
                        sck_n = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            mosi_n  = 1'b0;
                            state_n = HOLD;
                        end else begin
                            mosi_n    = tx_sr[6];
                            tx_sr_n   = {tx_sr[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else begin
                        sck_n   = 1'b1;
                        rx_sr_n = {rx_sr[6:0], MISO};
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    done_n    = 1'b1;
                    rx_data_n = rx_sr;
                    cnt_n     = RELOAD;
                    if (keep) begin
                        ready_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ssel_n  = 1'b1;
                        state_n = GUARD;
                    end
                end
            end
            GUARD: begin
                if (tick) begin
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: H=4 instance for most scenarios, H=1 instance
// for the fastest SCK rate.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       keep_ssel = 1'b0;
    logic       ready, done, sck, mosi, miso, ssel;
    logic [7:0] rx_data;
    logic       loop_mode = 1'b1;
    logic       miso_fix = 1'b0;

    logic       start1 = 1'b0;
    logic [7:0] tx_data1 = '0;
    logic       ready1, done1, sck1, mosi1, ssel1;
    logic [7:0] rx_data1;

    assign miso = loop_mode ? mosi : miso_fix;

    spi_master #(.HALF_PERIOD(4)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .keep_ssel(keep_ssel), .ready(ready), .done(done), .rx_data(rx_data),
        .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel)
    );

    spi_master #(.HALF_PERIOD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data1),
        .keep_ssel(1'b0), .ready(ready1), .done(done1), .rx_data(rx_data1),
        .SCK(sck1), .MOSI(mosi1), .MISO(mosi1), .SSEL(ssel1)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    int cyc = 0;

    // results of the last xfer() call, cycle numbers relative to the accepting edge
    int         e0, rel, rises, done_cnt, done_at, rdy_at, ssel_hi_at;
    logic [7:0] bits, rx_at_done;
    logic       mosi_hi, prev_sck;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic xfer(input logic [7:0] d, input logic k, input int inj_at);
        start = 1'b1; tx_data = d; keep_ssel = k;
        step();
        start = 1'b0;
        e0 = cyc; rel = 0; rises = 0; bits = '0; done_cnt = 0; done_at = -1;
        rdy_at = -1; ssel_hi_at = -1; rx_at_done = '0;
        mosi_hi = mosi; prev_sck = sck;
        if (ssel) ssel_hi_at = 0;
        for (int i = 0; i < 200; i++) begin
            if (inj_at >= 0 && rel == inj_at - 1) begin
                start = 1'b1; tx_data = 8'hFF;
            end
            step();
            start = 1'b0;
            rel = cyc - e0;
            if (sck && !prev_sck) begin
                rises++;
                bits = {bits[6:0], mosi};
            end
            prev_sck = sck;
            if (mosi) mosi_hi = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = rel;
                rx_at_done = rx_data;
            end
            if (ssel && ssel_hi_at < 0) ssel_hi_at = rel;
            if (ready) begin
                rdy_at = rel;
                break;
            end
        end
        if (rdy_at < 0) begin
            vec++; errs++;
            $display("FAIL xfer_timeout: ready never returned, tx=%h", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; tx_data = 8'hA5;
        step(); step();
        rst = 1'b0; start = 1'b0;
        vec++; if (sck !== 1'b0)   begin errs++; $display("FAIL rst_sck: got %b want 0", sck); end
        vec++; if (mosi !== 1'b0)  begin errs++; $display("FAIL rst_mosi: got %b want 0", mosi); end
        vec++; if (ssel !== 1'b1)  begin errs++; $display("FAIL rst_ssel: got %b want 1", ssel); end
        vec++; if (done !== 1'b0)  begin errs++; $display("FAIL rst_done: got %b want 0", done); end
        vec++; if (ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", ready); end
        vec++; if (rx_data !== 8'h00) begin errs++; $display("FAIL rst_rx: got %h want 00", rx_data); end
        step();
        vec++; if (ready !== 1'b1 || ssel !== 1'b1)
            begin errs++; $display("FAIL rst_start_discard: ready=%b ssel=%b want 1 1", ready, ssel); end
    endtask

    task automatic test_loopback_a5();
        loop_mode = 1'b1;
        xfer(8'hA5, 1'b0, -1);
        vec++; if (rises !== 8)       begin errs++; $display("FAIL a5_rises: got %0d want 8", rises); end
        vec++; if (bits !== 8'hA5)    begin errs++; $display("FAIL a5_mosi_bits: got %h want a5", bits); end
        vec++; if (done_at !== 68)    begin errs++; $display("FAIL a5_done_at: got %0d want 68", done_at); end
        vec++; if (done_cnt !== 1)    begin errs++; $display("FAIL a5_done_cnt: got %0d want 1", done_cnt); end
        vec++; if (rx_at_done !== 8'hA5) begin errs++; $display("FAIL a5_rx: got %h want a5", rx_at_done); end
        vec++; if (ssel_hi_at !== 68) begin errs++; $display("FAIL a5_ssel_hi: got %0d want 68", ssel_hi_at); end
        vec++; if (rdy_at !== 72)     begin errs++; $display("FAIL a5_ready_at: got %0d want 72", rdy_at); end
    endtask

    task automatic test_miso_ones();
        loop_mode = 1'b0; miso_fix = 1'b1;
        xfer(8'h00, 1'b0, -1);
        loop_mode = 1'b1;
        vec++; if (rx_at_done !== 8'hFF) begin errs++; $display("FAIL ones_rx: got %h want ff", rx_at_done); end
        vec++; if (mosi_hi !== 1'b0)     begin errs++; $display("FAIL ones_mosi: got %b want 0", mosi_hi); end
        vec++; if (rises !== 8)          begin errs++; $display("FAIL ones_rises: got %0d want 8", rises); end
    endtask

    task automatic test_back_to_back();
        int r1, d1, s1, rd1, dn1;
        logic [7:0] x1;
        xfer(8'h3C, 1'b1, -1);
        r1 = rises; d1 = done_at; s1 = ssel_hi_at; rd1 = rdy_at; x1 = rx_at_done; dn1 = done_cnt;
        xfer(8'hC3, 1'b0, -1);
        vec++; if (s1 !== -1)    begin errs++; $display("FAIL b2b_ssel_first: ssel high at %0d want never", s1); end
        vec++; if (rd1 !== 68 || d1 !== 68)
            begin errs++; $display("FAIL b2b_ready_with_done: ready %0d done %0d want 68 68", rd1, d1); end
        vec++; if (ssel_hi_at !== 68) begin errs++; $display("FAIL b2b_ssel_second: got %0d want 68", ssel_hi_at); end
        vec++; if (r1 + rises !== 16) begin errs++; $display("FAIL b2b_rises: got %0d want 16", r1 + rises); end
        vec++; if (dn1 + done_cnt !== 2) begin errs++; $display("FAIL b2b_dones: got %0d want 2", dn1 + done_cnt); end
        vec++; if (x1 !== 8'h3C)      begin errs++; $display("FAIL b2b_rx1: got %h want 3c", x1); end
        vec++; if (rx_at_done !== 8'hC3) begin errs++; $display("FAIL b2b_rx2: got %h want c3", rx_at_done); end
    endtask

    task automatic test_ignored_start();
        xfer(8'h66, 1'b0, 10);
        vec++; if (bits !== 8'h66)       begin errs++; $display("FAIL ign_mosi_bits: got %h want 66", bits); end
        vec++; if (rx_at_done !== 8'h66) begin errs++; $display("FAIL ign_rx: got %h want 66", rx_at_done); end
        vec++; if (done_cnt !== 1)       begin errs++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
        step();
        vec++; if (ssel !== 1'b1 || ready !== 1'b1)
            begin errs++; $display("FAIL ign_no_queue: ssel=%b ready=%b want 1 1", ssel, ready); end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        saw_done = 1'b0;
        start = 1'b1; tx_data = 8'hF0; keep_ssel = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        vec++; if (sck !== 1'b1) begin errs++; $display("FAIL rm_rise3: sck=%b want 1", sck); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (done) saw_done = 1'b1;
        vec++; if (sck !== 1'b0 || ssel !== 1'b1 || ready !== 1'b1)
            begin errs++; $display("FAIL rm_abort: sck=%b ssel=%b ready=%b want 0 1 1", sck, ssel, ready); end
        step();
        if (done) saw_done = 1'b1;
        vec++; if (saw_done !== 1'b0) begin errs++; $display("FAIL rm_no_done: got %b want 0", saw_done); end
        xfer(8'h5A, 1'b0, -1);
        vec++; if (rx_at_done !== 8'h5A || done_at !== 68)
            begin errs++; $display("FAIL rm_after: rx=%h done_at=%0d want 5a 68", rx_at_done, done_at); end
    endtask

    task automatic test_half1();
        int rise_first, rise_last, n, dat, e;
        logic ps;
        logic [7:0] rx;
        rise_first = -1; rise_last = -1; n = 0; dat = -1; rx = '0;
        start1 = 1'b1; tx_data1 = 8'h81;
        step();
        start1 = 1'b0;
        e = cyc; ps = sck1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sck1 && !ps) begin
                n++;
                if (rise_first < 0) rise_first = cyc - e;
                rise_last = cyc - e;
            end
            ps = sck1;
            if (done1) begin dat = cyc - e; rx = rx_data1; end
            if (ready1) break;
        end
        vec++; if (n !== 8) begin errs++; $display("FAIL h1_rises: got %0d want 8", n); end
        vec++; if (rise_first !== 1 || rise_last !== 15)
            begin errs++; $display("FAIL h1_period: rises %0d..%0d want 1..15", rise_first, rise_last); end
        vec++; if (dat !== 17)      begin errs++; $display("FAIL h1_done_at: got %0d want 17", dat); end
        vec++; if (rx !== 8'h81)    begin errs++; $display("FAIL h1_rx: got %h want 81", rx); end
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_miso_ones();
        step();
        test_back_to_back();
        step();
        test_ignored_start();
        test_reset_mid();
        test_half1();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
